seq_subtractor: RTL and testbench

- Multi-cycle WIDTH-bit subtractor computing diff = a - b - bin.
- Processes CHUNK bits per cycle through one CHUNK-bit add cell, with b inverted and the carry-in derived from the borrow.
- Companion to the ripple-carry adder datapath: it is the inverse arithmetic operation, with a sequential, area-lean structure.
- Valid/ready handshake on the operand side and on the result side.

---
 rtl/seq_subtractor.sv | 127 ++++++++++++
 tb/tb_seq_subtractor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle through one add cell (a + ~b + carry).
// Optional signed-overflow output ovf is built only when SEQ_SUB_OVF_EN is defined.
module seq_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SEQ_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and the producer holds data until accepted.
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_out_valid;
  logic [IW-1:0]    w_base;
  logic [CHUNK:0]   w_sum;
  logic             w_last;

  assign w_base = IW'(32'(r_cnt) * CHUNK);
  assign w_last = (r_cnt == CW'(NCHUNK - 1));
  // Subtraction as addition: invert b, carry-in is the complement of the borrow.
  assign w_sum  = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, ~r_b[w_base +: CHUNK]}
                + {{CHUNK{1'b0}}, r_carry};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand registers are only meaningful during RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry <= ~bin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_diff[w_base +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry                 <= w_sum[CHUNK];
          if (w_last) begin
            r_bout      <= ~w_sum[CHUNK];
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

`ifdef SEQ_SUB_OVF_EN
  logic r_ovf;
  // Overflow only when operand signs differ and the result sign departs from the minuend's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_a[WIDTH-1] != r_b[WIDTH-1]) & (w_sum[CHUNK-1] != r_a[WIDTH-1]);
    end
  end
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Table-driven bench for seq_subtractor with a result scoreboard queue; ovf checks build with SEQ_SUB_OVF_EN.
module tb_seq_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf_s;
  logic [1:0]   dbg_state;

  seq_subtractor #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SEQ_SUB_OVF_EN
    .ovf       (ovf_s),
`endif
    .dbg_state (dbg_state)
  );

`ifndef SEQ_SUB_OVF_EN
  assign ovf_s = 1'b0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  logic [W+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result built from plain wide subtraction.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0] t;
    logic       ov;
    t  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    ov = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin,
                      input logic [W+1:0] exp);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = sa;
    b        = sb;
    bin      = sbin;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    logic [W+1:0] e;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (out_valid) begin
        check("diff", {16'd0, diff}, {16'd0, e[W-1:0]});
        check("bout", {31'd0, bout}, {31'd0, e[W]});
`ifdef SEQ_SUB_OVF_EN
        check("ovf", {31'd0, ovf_s}, {31'd0, e[W+1]});
`endif
      end
    end
  endtask

  // Full operation with out_ready high: 4-cycle latency, one-cycle out_valid.
  task automatic op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin,
                    input logic [W+1:0] exp);
    int lat;
    send(sa, sb, sbin, exp);
    wait_result(lat);
    check("latency", lat, 32'd4);
    @(posedge clk); #1;
    check("out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];

  initial begin
    int           lat;
    logic [W-1:0] hd;
    logic         hb;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[6] = '{16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0};
    tbl[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_ovf", {31'd0, ovf_s}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op(tbl[i].a, tbl[i].b, tbl[i].bin, {tbl[i].ov, tbl[i].bo, tbl[i].d});

    // Backpressure: result held 10 cycles, new operands ignored.
    out_ready = 1'b0;
    send(16'h1234, 16'h0234, 1'b0, {1'b0, 1'b0, 16'h1000});
    wait_result(lat);
    hd = diff;
    hb = bout;
    in_valid = 1'b1;
    a        = 16'hFFFF;
    b        = 16'h0000;
    bin      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_diff", {16'd0, diff}, 32'h1000);
      check("hold_bout", {31'd0, bout}, {31'd0, hb});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    check("hold_diff_same", {16'd0, diff}, {16'd0, hd});
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("no_capture_state", {30'd0, dbg_state}, 32'd0);
    check("no_capture_diff", {16'd0, diff}, 32'h1000);

    // Reset in the middle of RUN drops the operation.
    send(16'hABCD, 16'h1111, 1'b0, {1'b0, 1'b0, 16'h9ABC});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff", {16'd0, diff}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    op(16'hABCD, 16'h1111, 1'b0, {1'b0, 1'b0, 16'h9ABC});

    // Random operands against the wide-subtraction model.
    for (int i = 0; i < 12; i++) begin
      ra   = W'($urandom_range(0, 65535));
      rb   = W'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      op(ra, rb, rbin, model(ra, rb, rbin));
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
